// File: rtl/msrv32_pkg.sv
// Shared definitions for the msrv32 fetch stage: FSM and redirect-source encodings,
// reset/fill constants and target-alignment helpers.
package msrv32_pkg;

  localparam logic [31:0] BOOT_ADDRESS_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF    = 32'h0000_0013;
  localparam logic [31:0] FETCH_STRIDE     = 32'd4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3,
    ST_DROP = 3'd4
  } fetch_state_e;

  typedef enum logic [1:0] {
    RD_NONE   = 2'd0,
    RD_BRANCH = 2'd1,
    RD_MRET   = 2'd2,
    RD_TRAP   = 2'd3
  } redir_src_e;

  // Trap beats mret beats branch when several pulses land in the same cycle.
  function automatic redir_src_e redir_select(input logic trap,
                                              input logic mret,
                                              input logic branch);
    redir_src_e src;
    src = RD_NONE;
    if (trap) begin
      src = RD_TRAP;
    end else if (mret) begin
      src = RD_MRET;
    end else if (branch) begin
      src = RD_BRANCH;
    end
    return src;
  endfunction

  // Bit0 is always dropped (JALR rule); bit1 survives only when the caller checks it.
  function automatic logic [31:0] align_target(input logic [31:0] addr,
                                               input logic        keep_bit1);
    logic [31:0] res;
    res = {addr[31:1], 1'b0};
    if (!keep_bit1) begin
      res[1] = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/msrv32_fetch_unit_if.sv
// Instruction-memory and decode-slot handshakes of the fetch stage.
// MSRV32_MISALIGN_CHK_EN adds the misaligned_instr_out fault flag.
interface msrv32_fetch_unit_if;

  logic        imem_req_valid_out;
  logic        imem_req_ready_in;
  logic [31:0] imem_addr_out;
  logic        imem_rsp_valid_in;
  logic [31:0] imem_rsp_data_in;
  logic        instr_valid_out;
  logic        instr_ready_in;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
`ifdef MSRV32_MISALIGN_CHK_EN
  logic        misaligned_instr_out;

  modport master (
    output imem_req_valid_out, imem_addr_out,
    input  imem_req_ready_in, imem_rsp_valid_in, imem_rsp_data_in,
    output instr_valid_out, instr_out, pc_out, misaligned_instr_out,
    input  instr_ready_in
  );

  modport slave (
    input  imem_req_valid_out, imem_addr_out,
    output imem_req_ready_in, imem_rsp_valid_in, imem_rsp_data_in,
    input  instr_valid_out, instr_out, pc_out, misaligned_instr_out,
    output instr_ready_in
  );
`else
  modport master (
    output imem_req_valid_out, imem_addr_out,
    input  imem_req_ready_in, imem_rsp_valid_in, imem_rsp_data_in,
    output instr_valid_out, instr_out, pc_out,
    input  instr_ready_in
  );

  modport slave (
    input  imem_req_valid_out, imem_addr_out,
    output imem_req_ready_in, imem_rsp_valid_in, imem_rsp_data_in,
    input  instr_valid_out, instr_out, pc_out,
    output instr_ready_in
  );
`endif

endinterface

// File: rtl/msrv32_fetch_slot.sv
// One-entry decode output register: load beats clear, clear beats drain, otherwise hold.
// MSRV32_MISALIGN_CHK_EN adds a fault flag carried alongside the entry.
module msrv32_fetch_slot
  import msrv32_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        load_in,
  input  logic        clear_in,
  input  logic [31:0] load_pc_in,
  input  logic [31:0] load_instr_in,
`ifdef MSRV32_MISALIGN_CHK_EN
  input  logic        load_misal_in,
  output logic        misal_out,
`endif
  input  logic        ready_in,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out
);

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
`ifdef MSRV32_MISALIGN_CHK_EN
  logic        misal_q, misal_d;
`endif

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
`ifdef MSRV32_MISALIGN_CHK_EN
    misal_d = misal_q;
`endif
    if (load_in) begin
      valid_d = 1'b1;
      pc_d    = load_pc_in;
      instr_d = load_instr_in;
`ifdef MSRV32_MISALIGN_CHK_EN
      misal_d = load_misal_in;
`endif
    end else if (clear_in || (valid_q && ready_in)) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      valid_q <= 1'b0;
      pc_q    <= 32'h0000_0000;
      instr_q <= NOP_INSTR;
`ifdef MSRV32_MISALIGN_CHK_EN
      misal_q <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
`ifdef MSRV32_MISALIGN_CHK_EN
      misal_q <= misal_d;
`endif
    end
  end

  assign valid_out = valid_q;
  assign pc_out    = pc_q;
  assign instr_out = instr_q;
`ifdef MSRV32_MISALIGN_CHK_EN
  assign misal_out = valid_q & misal_q;
`endif

endmodule

// File: rtl/msrv32_fetch_unit.sv
// RV32 fetch stage: PC, single-outstanding imem request FSM, redirect squashing, decode slot.
// MSRV32_MISALIGN_CHK_EN turns bit1-set targets into a fault slot instead of a fetch.
module msrv32_fetch_unit
  import msrv32_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDRESS = BOOT_ADDRESS_DEF,
  parameter logic [31:0] NOP_INSTR    = NOP_INSTR_DEF
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 branch_taken_in,
  input  logic [31:0]          target_addr_in,
  input  logic                 trap_taken_in,
  input  logic [31:0]          trap_addr_in,
  input  logic                 mret_in,
  input  logic [31:0]          epc_in,
  msrv32_fetch_unit_if.master  bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic         squash_q, squash_d;

  redir_src_e   rsrc;
  logic         redirect;
  logic [31:0]  raw_tgt;
  logic [31:0]  tgt;
  logic         accept;
  logic         rsp;
  logic         slot_drain;
  logic         slot_load;
  logic         slot_clear;
  logic [31:0]  load_pc;
  logic [31:0]  load_instr;
`ifdef MSRV32_MISALIGN_CHK_EN
  logic         tgt_misal;
  logic         load_misal;
  logic         fault_q, fault_d;
`endif

  always_comb begin
    rsrc     = redir_select(trap_taken_in, mret_in, branch_taken_in);
    redirect = (rsrc != RD_NONE);
    case (rsrc)
      RD_TRAP: raw_tgt = trap_addr_in;
      RD_MRET: raw_tgt = epc_in;
      default: raw_tgt = target_addr_in;
    endcase
`ifdef MSRV32_MISALIGN_CHK_EN
    tgt       = align_target(raw_tgt, 1'b1);
    tgt_misal = redirect & tgt[1];
`else
    tgt       = align_target(raw_tgt, 1'b0);
`endif
  end

  assign bus.imem_req_valid_out = (state_q == ST_REQ);
  assign bus.imem_addr_out      = addr_q;
  assign accept     = bus.imem_req_valid_out & bus.imem_req_ready_in;
  assign rsp        = bus.imem_rsp_valid_in;
  assign slot_drain = bus.instr_valid_out & bus.instr_ready_in;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    squash_d   = squash_q;
    slot_load  = 1'b0;
    slot_clear = 1'b0;
    load_pc    = addr_q;
    load_instr = bus.imem_rsp_data_in;
`ifdef MSRV32_MISALIGN_CHK_EN
    load_misal = 1'b0;
    fault_d    = fault_q;
`endif

    if (redirect) begin
      pc_d       = tgt;
      slot_clear = 1'b1;
    end

    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        // The handshake already on the bus must complete; a pending squash turns it into a DROP.
        if (accept) begin
          state_d  = (squash_q || redirect) ? ST_DROP : ST_WAIT;
          squash_d = 1'b0;
        end else if (redirect) begin
          squash_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          state_d = rsp ? ST_REQ : ST_DROP;
        end else if (rsp) begin
          // The slot is full next cycle, so the next request waits for it to drain in HOLD.
          slot_load = 1'b1;
          pc_d      = pc_q + FETCH_STRIDE;
          state_d   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (redirect || slot_drain) begin
          state_d = ST_REQ;
        end
      end
      ST_DROP: begin
        if (rsp) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef MSRV32_MISALIGN_CHK_EN
    if (tgt_misal) begin
      slot_load  = 1'b1;
      load_pc    = tgt;
      load_instr = NOP_INSTR;
      load_misal = 1'b1;
      fault_d    = 1'b1;
    end else if (rsrc == RD_TRAP) begin
      fault_d = 1'b0;
    end
    // While parked on a fault, every would-be fresh fetch stays in HOLD until a trap arrives.
    if (fault_d && (state_d == ST_REQ) && (state_q != ST_REQ)) begin
      state_d = ST_HOLD;
    end
`endif

    if ((state_d == ST_REQ) && (state_q != ST_REQ)) begin
      addr_d = pc_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q  <= ST_IDLE;
      pc_q     <= BOOT_ADDRESS;
      addr_q   <= BOOT_ADDRESS;
      squash_q <= 1'b0;
`ifdef MSRV32_MISALIGN_CHK_EN
      fault_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      squash_q <= squash_d;
`ifdef MSRV32_MISALIGN_CHK_EN
      fault_q  <= fault_d;
`endif
    end
  end

  msrv32_fetch_slot #(
    .NOP_INSTR (NOP_INSTR)
  ) u_slot (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .load_in       (slot_load),
    .clear_in      (slot_clear),
    .load_pc_in    (load_pc),
    .load_instr_in (load_instr),
`ifdef MSRV32_MISALIGN_CHK_EN
    .load_misal_in (load_misal),
    .misal_out     (bus.misaligned_instr_out),
`endif
    .ready_in      (bus.instr_ready_in),
    .valid_out     (bus.instr_valid_out),
    .pc_out        (bus.pc_out),
    .instr_out     (bus.instr_out)
  );

endmodule

// File: tb/tb_msrv32_fetch_unit.sv
// Directed bench for msrv32_fetch_unit; memory returns 32'hC0DE_xxxx with xxxx = addr[15:0].
// Covers MSRV32_MISALIGN_CHK_EN when that macro is defined.
module tb_msrv32_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        br = 1'b0;
  logic        trap = 1'b0;
  logic        mret = 1'b0;
  logic [31:0] tgt = 32'h0;
  logic [31:0] trap_addr = 32'h0;
  logic [31:0] epc = 32'h0;

  int          total = 0;
  int          bad = 0;
  int          mem_lat = 1;
  int          pend_cnt = 0;
  logic [31:0] pend_data = 32'h0;
  logic [31:0] acc_q[$];

  msrv32_fetch_unit_if bus();

  msrv32_fetch_unit #(
    .BOOT_ADDRESS (32'h0000_0000),
    .NOP_INSTR    (32'h0000_0013)
  ) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .branch_taken_in (br),
    .target_addr_in  (tgt),
    .trap_taken_in   (trap),
    .trap_addr_in    (trap_addr),
    .mret_in         (mret),
    .epc_in          (epc),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: memory accepts what was on the bus before the edge and answers mem_lat cycles later.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    acc = bus.imem_req_valid_out && bus.imem_req_ready_in;
    a   = bus.imem_addr_out;
    @(posedge clk);
    #1;
    bus.imem_rsp_valid_in = 1'b0;
    if (acc) begin
      acc_q.push_back(a);
      pend_cnt  = mem_lat;
      pend_data = 32'hC0DE_0000 | {16'h0000, a[15:0]};
    end
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        bus.imem_rsp_valid_in = 1'b1;
        bus.imem_rsp_data_in  = pend_data;
      end
    end
  endtask

  task automatic run_until_slot(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.instr_valid_out && n < 20);
    chk("slot_seen", {31'b0, bus.instr_valid_out}, 32'h1);
  endtask

  initial begin
    int          n;
    int          nacc;
    logic [31:0] nxt;
    logic [31:0] last_acc;

    bus.imem_req_ready_in = 1'b1;
    bus.imem_rsp_valid_in = 1'b0;
    bus.imem_rsp_data_in  = 32'h0;
    bus.instr_ready_in    = 1'b1;

    // reset state
    tick();
    tick();
    chk("rst_req_valid", {31'b0, bus.imem_req_valid_out}, 32'h0);
    chk("rst_instr_valid", {31'b0, bus.instr_valid_out}, 32'h0);
    chk("rst_instr", bus.instr_out, 32'h0000_0013);
    chk("rst_pc", bus.pc_out, 32'h0);
    chk("rst_addr", bus.imem_addr_out, 32'h0);
    rst_n = 1'b1;

    // sequential fetch 0,4,8
    run_until_slot(n);
    chk("boot_lat", n, 32'd3);
    chk("seq0_pc", bus.pc_out, 32'h0);
    chk("seq0_instr", bus.instr_out, 32'hC0DE_0000);
    run_until_slot(n);
    chk("seq4_lat", n, 32'd3);
    chk("seq4_pc", bus.pc_out, 32'h4);
    chk("seq4_instr", bus.instr_out, 32'hC0DE_0004);
    run_until_slot(n);
    chk("seq8_pc", bus.pc_out, 32'h8);
    chk("seq8_instr", bus.instr_out, 32'hC0DE_0008);
    chk("acc_count", acc_q.size(), 32'd3);
    chk("acc0", acc_q[0], 32'h0);
    chk("acc1", acc_q[1], 32'h4);
    chk("acc2", acc_q[2], 32'h8);

    // branch while waiting (2-cycle memory) on addr 0xC
    mem_lat = 2;
    tick();
    chk("br_req_addr", bus.imem_addr_out, 32'hC);
    tick();
    br = 1'b1;
    tgt = 32'h0000_0100;
    tick();
    br = 1'b0;
    chk("br_drop_noreq", {31'b0, bus.imem_req_valid_out}, 32'h0);
    tick();
    chk("br_no_slot_c", {31'b0, bus.instr_valid_out}, 32'h0);
    chk("br_new_addr", bus.imem_addr_out, 32'h100);
    chk("br_new_valid", {31'b0, bus.imem_req_valid_out}, 32'h1);
    mem_lat = 1;
    run_until_slot(n);
    chk("br_slot_pc", bus.pc_out, 32'h100);
    chk("br_slot_instr", bus.instr_out, 32'hC0DE_0100);

    // decode stall: five cycles with a full slot
    bus.instr_ready_in = 1'b0;
    nacc = acc_q.size();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_ctl", {30'b0, bus.instr_valid_out, bus.imem_req_valid_out}, 32'h2);
      chk("stall_pc", bus.pc_out, 32'h100);
      chk("stall_instr", bus.instr_out, 32'hC0DE_0100);
    end
    chk("stall_no_acc", acc_q.size(), nacc);
    bus.instr_ready_in = 1'b1;
    tick();
    chk("resume_valid", {31'b0, bus.imem_req_valid_out}, 32'h1);
    chk("resume_addr", bus.imem_addr_out, 32'h104);

    // trap and branch together, request accepted in the same cycle
    trap = 1'b1;
    trap_addr = 32'h0000_0080;
    br = 1'b1;
    tgt = 32'h0000_0200;
    tick();
    trap = 1'b0;
    br = 1'b0;
    chk("prio_drop", {31'b0, bus.imem_req_valid_out}, 32'h0);
    tick();
    chk("prio_addr", bus.imem_addr_out, 32'h80);
    run_until_slot(n);
    chk("prio_pc", bus.pc_out, 32'h80);
    chk("prio_instr", bus.instr_out, 32'hC0DE_0080);

    // mret while the request is not yet accepted
    bus.imem_req_ready_in = 1'b0;
    tick();
    chk("sq_addr0", bus.imem_addr_out, 32'h84);
    mret = 1'b1;
    epc = 32'h0000_0044;
    tick();
    mret = 1'b0;
    chk("sq_hold_valid", {31'b0, bus.imem_req_valid_out}, 32'h1);
    chk("sq_hold_addr", bus.imem_addr_out, 32'h84);
    tick();
    chk("sq_hold_addr2", bus.imem_addr_out, 32'h84);
    bus.imem_req_ready_in = 1'b1;
    tick();
    chk("sq_drop", {31'b0, bus.imem_req_valid_out}, 32'h0);
    tick();
    chk("mret_addr", bus.imem_addr_out, 32'h44);
    run_until_slot(n);
    chk("mret_pc", bus.pc_out, 32'h44);
    chk("mret_instr", bus.instr_out, 32'hC0DE_0044);

    // wrap-around and redirect-to-valid latency
    br = 1'b1;
    tgt = 32'hFFFF_FFFC;
    tick();
    br = 1'b0;
    chk("wrap_req", bus.imem_addr_out, 32'hFFFF_FFFC);
    chk("wrap_cleared", {31'b0, bus.instr_valid_out}, 32'h0);
    run_until_slot(n);
    chk("redir_lat", n + 1, 32'd3);
    chk("wrap_pc", bus.pc_out, 32'hFFFF_FFFC);
    chk("wrap_instr", bus.instr_out, 32'hC0DE_FFFC);
    tick();
    chk("wrap_next_addr", bus.imem_addr_out, 32'h0);
    chk("wrap_next_valid", {31'b0, bus.imem_req_valid_out}, 32'h1);

`ifdef MSRV32_MISALIGN_CHK_EN
    // misaligned target parks the stage on a fault slot
    br = 1'b1;
    tgt = 32'h0000_0102;
    tick();
    br = 1'b0;
    bus.instr_ready_in = 1'b0;
    chk("mis_valid", {31'b0, bus.instr_valid_out}, 32'h1);
    chk("mis_flag", {31'b0, bus.misaligned_instr_out}, 32'h1);
    chk("mis_pc", bus.pc_out, 32'h102);
    chk("mis_instr", bus.instr_out, 32'h0000_0013);
    tick();
    chk("mis_noreq1", {31'b0, bus.imem_req_valid_out}, 32'h0);
    bus.instr_ready_in = 1'b1;
    tick();
    chk("mis_noreq2", {31'b0, bus.imem_req_valid_out}, 32'h0);
    last_acc = acc_q[acc_q.size() - 1];
    chk("mis_last_acc", last_acc, 32'h0);
    trap = 1'b1;
    trap_addr = 32'h0000_0080;
    tick();
    trap = 1'b0;
    chk("mis_trap_addr", bus.imem_addr_out, 32'h80);
    run_until_slot(n);
    chk("mis_trap_pc", bus.pc_out, 32'h80);
    nxt = 32'h84;
`else
    // low target bits are dropped and the fetch goes ahead
    br = 1'b1;
    tgt = 32'h0000_0203;
    tick();
    br = 1'b0;
    chk("al_drop", {31'b0, bus.imem_req_valid_out}, 32'h0);
    tick();
    chk("al_addr", bus.imem_addr_out, 32'h200);
    run_until_slot(n);
    chk("al_pc", bus.pc_out, 32'h200);
    chk("al_instr", bus.instr_out, 32'hC0DE_0200);
    nxt = 32'h204;
`endif

    // reset in WAIT with a late response
    mem_lat = 3;
    tick();
    chk("rw_req", bus.imem_addr_out, nxt);
    tick();
    chk("rw_wait", {31'b0, bus.imem_req_valid_out}, 32'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rw_rst_req", {31'b0, bus.imem_req_valid_out}, 32'h0);
    chk("rw_rst_addr", bus.imem_addr_out, 32'h0);
    chk("rw_rst_slot", {31'b0, bus.instr_valid_out}, 32'h0);
    mem_lat = 1;
    bus.imem_req_ready_in = 1'b0;
    tick();
    chk("rw_boot_addr", bus.imem_addr_out, 32'h0);
    chk("rw_boot_valid", {31'b0, bus.imem_req_valid_out}, 32'h1);
    tick();
    chk("rw_late_ignored", {31'b0, bus.instr_valid_out}, 32'h0);
    chk("rw_still_req", {31'b0, bus.imem_req_valid_out}, 32'h1);
    bus.imem_req_ready_in = 1'b1;
    run_until_slot(n);
    chk("rw_lat", n, 32'd2);
    chk("rw_pc", bus.pc_out, 32'h0);
    chk("rw_instr", bus.instr_out, 32'hC0DE_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
